// File: rtl/histogram_compute_pkg.sv
// Shared definitions for the histogram-equalisation blocks: bin geometry,
// pixel width and the histogram controller state encoding.
package histogram_compute_pkg;

  localparam int NUM_BINS = 256;
  localparam int PIX_W    = 8;
  localparam int BIN_AW   = 8;

  typedef logic [PIX_W-1:0]  pixel_t;
  typedef logic [BIN_AW-1:0] bin_addr_t;

  // Controller states, kept as plain constants so older code can compare
  // against them directly.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_ACCUM = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam bin_addr_t LAST_BIN = 8'd255;

  // True on the final bin of the clear sweep.
  function automatic logic is_last_bin(input bin_addr_t idx);
    return (idx == LAST_BIN);
  endfunction

endpackage

// File: rtl/histogram_compute_rmw_pipe.sv
// Read-modify-write pipeline for histogram bins.
// Stage 1: the pixel arrives from input memory and addresses the bin read.
// Stage 2: the bin value arrives, is incremented (saturating) and written.
// A write to the same bin in the previous cycle is forwarded because the
// scratch memory returns old data on a same-address read-during-write.
module hist_rmw_pipe
  import histogram_compute_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               pix_issue,
  input  pixel_t             pix_data,
  input  logic [COUNT_W-1:0] scratch_rd_data,
  output logic               scratch_rd_en,
  output bin_addr_t          scratch_rd_addr,
  output logic               pipe_wr_en,
  output bin_addr_t          pipe_wr_addr,
  output logic [COUNT_W-1:0] pipe_wr_data,
  output logic               sat_hit,
  output logic               rd_stage_valid
);

  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

  logic               rd_valid_r;
  logic               wr_valid_r;
  pixel_t             wr_bin_r;
  logic               prev_wr_valid_r;
  pixel_t             prev_wr_bin_r;
  logic [COUNT_W-1:0] prev_wr_data_r;

  logic               fwd_s;
  logic [COUNT_W-1:0] count_s;

  // Increment that sticks at the top of the counter range.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
    if (c == COUNT_MAX) begin
      return COUNT_MAX;
    end else begin
      return c + COUNT_W'(1);
    end
  endfunction

  // Advance the pixel through the read and write stages; remember the last write.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid_r      <= 1'b0;
      wr_valid_r      <= 1'b0;
      wr_bin_r        <= 8'd0;
      prev_wr_valid_r <= 1'b0;
      prev_wr_bin_r   <= 8'd0;
      prev_wr_data_r  <= {COUNT_W{1'b0}};
    end else begin
      rd_valid_r      <= pix_issue;
      wr_valid_r      <= rd_valid_r;
      wr_bin_r        <= pix_data;
      prev_wr_valid_r <= wr_valid_r;
      prev_wr_bin_r   <= wr_bin_r;
      prev_wr_data_r  <= pipe_wr_data;
    end
  end

  // Select the current bin count (forwarded or from memory) and form the write.
  always_comb begin
    fwd_s = prev_wr_valid_r && (prev_wr_bin_r == wr_bin_r);
    if (fwd_s) begin
      count_s = prev_wr_data_r;
    end else begin
      count_s = scratch_rd_data;
    end
    scratch_rd_en   = rd_valid_r && !reset;
    scratch_rd_addr = pix_data;
    pipe_wr_en      = wr_valid_r && !reset;
    pipe_wr_addr    = wr_bin_r;
    pipe_wr_data    = sat_inc(count_s);
    sat_hit         = pipe_wr_en && (count_s == COUNT_MAX);
    rd_stage_valid  = rd_valid_r;
  end

endmodule

// File: rtl/histogram_compute.sv
// Histogram controller: clears all 256 bins, streams every pixel of the image
// through the read-modify-write pipe, waits for the last write and pulses done.
module histogram_compute
  import histogram_compute_pkg::*;
#(
  parameter int NUM_PIXELS = 16384,
  parameter int ADDR_W     = 14,
  parameter int COUNT_W    = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               histogram_start_pulse,
  input  logic               histogram_en,
  output logic               input_mem_rd_en,
  output logic [ADDR_W-1:0]  input_mem_addr,
  input  logic [7:0]         input_mem_rd_data,
  output logic               scratch_rd_en,
  output logic [7:0]         scratch_rd_addr,
  input  logic [COUNT_W-1:0] scratch_rd_data,
  output logic               scratch_wr_en,
  output logic [7:0]         scratch_wr_addr,
  output logic [COUNT_W-1:0] scratch_wr_data,
  output logic               input_mem_done,
  output logic               histogram_computation_done,
  output logic               histogram_saturated,
  output logic               busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

  logic [2:0]         state_r;
  logic [2:0]         state_nxt_s;
  bin_addr_t          clear_idx_r;
  logic [ADDR_W-1:0]  rd_addr_r;
  logic               imd_r;
  logic               done_r;
  logic               busy_r;
  logic               sat_r;

  logic               start_ok_s;
  logic               issue_s;
  logic               last_issue_s;
  logic               clear_wr_s;

  logic               pipe_rd_en_s;
  bin_addr_t          pipe_rd_addr_s;
  logic               pipe_wr_en_s;
  bin_addr_t          pipe_wr_addr_s;
  logic [COUNT_W-1:0] pipe_wr_data_s;
  logic               sat_hit_s;
  logic               rd_stage_valid_s;

  hist_rmw_pipe #(
    .COUNT_W (COUNT_W)
  ) u_rmw_pipe (
    .clock           (clock),
    .reset           (reset),
    .pix_issue       (issue_s),
    .pix_data        (input_mem_rd_data),
    .scratch_rd_data (scratch_rd_data),
    .scratch_rd_en   (pipe_rd_en_s),
    .scratch_rd_addr (pipe_rd_addr_s),
    .pipe_wr_en      (pipe_wr_en_s),
    .pipe_wr_addr    (pipe_wr_addr_s),
    .pipe_wr_data    (pipe_wr_data_s),
    .sat_hit         (sat_hit_s),
    .rd_stage_valid  (rd_stage_valid_s)
  );

  // Qualify start/issue and choose the next controller state.
  always_comb begin
    start_ok_s   = (state_r == ST_IDLE) && histogram_start_pulse;
    issue_s      = (state_r == ST_ACCUM) && histogram_en && !reset;
    last_issue_s = issue_s && (rd_addr_r == LAST_ADDR);
    clear_wr_s   = (state_r == ST_CLEAR) && !reset;
    state_nxt_s  = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) begin
          state_nxt_s = ST_CLEAR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (is_last_bin(clear_idx_r)) begin
          state_nxt_s = ST_ACCUM;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      ST_ACCUM: begin
        if (last_issue_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_ACCUM;
        end
      end
      ST_DRAIN: begin
        // With nothing left in the read stage, this cycle's write is the last.
        if (!rd_stage_valid_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Controller state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Clear sweep index: counts through the bins while clearing, parked at 0 otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      clear_idx_r <= 8'd0;
    end else if (state_r == ST_CLEAR) begin
      clear_idx_r <= clear_idx_r + 8'd1;
    end else begin
      clear_idx_r <= 8'd0;
    end
  end

  // Pixel address counter: advances only on cycles that issue a read.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_addr_r <= {ADDR_W{1'b0}};
    end else if (start_ok_s) begin
      rd_addr_r <= {ADDR_W{1'b0}};
    end else if (issue_s) begin
      rd_addr_r <= rd_addr_r + ADDR_W'(1);
    end else begin
      rd_addr_r <= rd_addr_r;
    end
  end

  // Registered status flags: busy, done pulse, address-issue complete, saturation.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      imd_r  <= 1'b0;
      sat_r  <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s != ST_IDLE);
      done_r <= (state_nxt_s == ST_DONE);
      if (start_ok_s) begin
        imd_r <= 1'b0;
      end else if (last_issue_s) begin
        imd_r <= 1'b1;
      end else begin
        imd_r <= imd_r;
      end
      if (start_ok_s) begin
        sat_r <= 1'b0;
      end else if (sat_hit_s) begin
        sat_r <= 1'b1;
      end else begin
        sat_r <= sat_r;
      end
    end
  end

  // Drive the memory strobes and status outputs; clear writes own the write port in CLEAR.
  always_comb begin
    input_mem_rd_en = issue_s;
    input_mem_addr  = rd_addr_r;
    scratch_rd_en   = pipe_rd_en_s;
    scratch_rd_addr = pipe_rd_addr_s;
    if (clear_wr_s) begin
      scratch_wr_en   = 1'b1;
      scratch_wr_addr = clear_idx_r;
      scratch_wr_data = {COUNT_W{1'b0}};
    end else begin
      scratch_wr_en   = pipe_wr_en_s;
      scratch_wr_addr = pipe_wr_addr_s;
      scratch_wr_data = pipe_wr_data_s;
    end
    input_mem_done             = imd_r;
    histogram_computation_done = done_r;
    histogram_saturated        = sat_r;
    busy                       = busy_r;
  end

endmodule

// File: tb/tb_histogram_compute.sv
// Bench for histogram_compute: two instances (16-bit and 4-bit counters) share
// clock, reset, start, enable and the pixel image; each has its own 1R1W bin memory.
module tb_histogram_compute;

  localparam int N = 16;

  logic clock = 1'b0;
  logic reset;
  logic start;
  logic en;
  logic fill;

  logic        a_ird_en, b_ird_en;
  logic [3:0]  a_iaddr, b_iaddr;
  logic [7:0]  a_ird_data = 8'd0;
  logic [7:0]  b_ird_data = 8'd0;
  logic        a_srd_en, b_srd_en;
  logic [7:0]  a_srd_addr, b_srd_addr;
  logic [15:0] a_srd_data = 16'd0;
  logic [3:0]  b_srd_data = 4'd0;
  logic        a_swr_en, b_swr_en;
  logic [7:0]  a_swr_addr, b_swr_addr;
  logic [15:0] a_swr_data;
  logic [3:0]  b_swr_data;
  logic        a_imd, b_imd, a_done, b_done, a_sat, b_sat, a_busy, b_busy;

  logic [7:0]  pix_mem [N];
  logic [15:0] a_mem [256];
  logic [3:0]  b_mem [256];

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  histogram_compute #(.NUM_PIXELS(N), .ADDR_W(4), .COUNT_W(16)) dut_a (
    .clock(clock), .reset(reset), .histogram_start_pulse(start), .histogram_en(en),
    .input_mem_rd_en(a_ird_en), .input_mem_addr(a_iaddr), .input_mem_rd_data(a_ird_data),
    .scratch_rd_en(a_srd_en), .scratch_rd_addr(a_srd_addr), .scratch_rd_data(a_srd_data),
    .scratch_wr_en(a_swr_en), .scratch_wr_addr(a_swr_addr), .scratch_wr_data(a_swr_data),
    .input_mem_done(a_imd), .histogram_computation_done(a_done),
    .histogram_saturated(a_sat), .busy(a_busy));

  histogram_compute #(.NUM_PIXELS(N), .ADDR_W(4), .COUNT_W(4)) dut_b (
    .clock(clock), .reset(reset), .histogram_start_pulse(start), .histogram_en(en),
    .input_mem_rd_en(b_ird_en), .input_mem_addr(b_iaddr), .input_mem_rd_data(b_ird_data),
    .scratch_rd_en(b_srd_en), .scratch_rd_addr(b_srd_addr), .scratch_rd_data(b_srd_data),
    .scratch_wr_en(b_swr_en), .scratch_wr_addr(b_swr_addr), .scratch_wr_data(b_swr_data),
    .input_mem_done(b_imd), .histogram_computation_done(b_done),
    .histogram_saturated(b_sat), .busy(b_busy));

  always #5 clock = ~clock;

  // Cycle counter: cycle k runs from posedge k to posedge k+1.
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural memories: registered reads, read-during-write returns old data.
  always @(posedge clock) begin
    if (a_ird_en) a_ird_data <= pix_mem[a_iaddr];
    if (b_ird_en) b_ird_data <= pix_mem[b_iaddr];
    if (a_srd_en) a_srd_data <= a_mem[a_srd_addr];
    if (b_srd_en) b_srd_data <= b_mem[b_srd_addr];
    if (fill) begin
      for (int i = 0; i < 256; i++) begin
        a_mem[i] <= 16'hBEEF;
        b_mem[i] <= 4'hB;
      end
    end else begin
      if (a_swr_en) a_mem[a_swr_addr] <= a_swr_data;
      if (b_swr_en) b_mem[b_swr_addr] <= b_swr_data;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int min_int(input int x, input int y);
    return (x < y) ? x : y;
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  typedef struct { int stamp; int pix; } ent_t;
  ent_t q[$];
  int   m_hist [256];
  bit   m_busy = 1'b0;
  bit   m_imd = 1'b0;
  bit   m_sat_a = 1'b0;
  bit   m_sat_b = 1'b0;
  int   m_start = -1000;
  int   m_reads = N;
  int   m_done_due = -1;

  always @(negedge clock) begin : mon
    bit exp_ird, exp_clr, exp_pw, exp_srd;
    int pw_pix, srd_pix;
    if (reset) begin
      chk("rst_ird_en", a_ird_en | b_ird_en, 0);
      chk("rst_srd_en", a_srd_en | b_srd_en, 0);
      chk("rst_swr_en", a_swr_en | b_swr_en, 0);
      m_busy = 1'b0; m_imd = 1'b0; m_sat_a = 1'b0; m_sat_b = 1'b0;
      m_start = -1000; m_reads = N; m_done_due = -1;
      q.delete();
    end else begin
      chk("busy_a", a_busy, m_busy);
      chk("busy_b", b_busy, m_busy);
      chk("done_a", a_done, cyc == m_done_due);
      chk("done_b", b_done, cyc == m_done_due);
      chk("imd_a", a_imd, m_imd);
      chk("imd_b", b_imd, m_imd);
      chk("sat_a", a_sat, m_sat_a);
      chk("sat_b", b_sat, m_sat_b);
      // Pixel reads: after the 256-cycle clear, one per enabled cycle until N issued.
      exp_ird = m_busy && (cyc >= m_start + 257) && (m_reads < N) && en;
      chk("ird_en_a", a_ird_en, exp_ird);
      chk("ird_en_b", b_ird_en, exp_ird);
      if (exp_ird) begin
        chk("iaddr_a", a_iaddr, m_reads);
        chk("iaddr_b", b_iaddr, m_reads);
        q.push_back('{cyc, int'(pix_mem[m_reads])});
        m_reads++;
        if (m_reads == N) begin
          m_imd = 1'b1;
          m_done_due = cyc + 3;
        end
      end
      // Writes: clear sweep, or the pixel read two cycles ago.
      exp_clr = m_busy && (cyc >= m_start + 1) && (cyc <= m_start + 256);
      exp_pw  = (q.size() > 0) && (q[0].stamp == cyc - 2);
      chk("swr_en_a", a_swr_en, exp_clr || exp_pw);
      chk("swr_en_b", b_swr_en, exp_clr || exp_pw);
      if (exp_clr) begin
        chk("clr_addr_a", a_swr_addr, cyc - m_start - 1);
        chk("clr_addr_b", b_swr_addr, cyc - m_start - 1);
        chk("clr_data_a", a_swr_data, 0);
        chk("clr_data_b", b_swr_data, 0);
      end else if (exp_pw) begin
        pw_pix = q[0].pix;
        chk("wr_addr_a", a_swr_addr, pw_pix);
        chk("wr_addr_b", b_swr_addr, pw_pix);
        chk("wr_data_a", a_swr_data, min_int(m_hist[pw_pix] + 1, 65535));
        chk("wr_data_b", b_swr_data, min_int(m_hist[pw_pix] + 1, 15));
        if (m_hist[pw_pix] >= 65535) m_sat_a = 1'b1;
        if (m_hist[pw_pix] >= 15) m_sat_b = 1'b1;
        m_hist[pw_pix]++;
        void'(q.pop_front());
      end
      // Bin reads: the pixel read in the previous cycle.
      exp_srd = 1'b0;
      srd_pix = 0;
      foreach (q[i]) begin
        if (q[i].stamp == cyc - 1) begin
          exp_srd = 1'b1;
          srd_pix = q[i].pix;
        end
      end
      chk("srd_en_a", a_srd_en, exp_srd);
      chk("srd_en_b", b_srd_en, exp_srd);
      if (exp_srd) begin
        chk("srd_addr_a", a_srd_addr, srd_pix);
        chk("srd_addr_b", b_srd_addr, srd_pix);
      end
      // Start is accepted only when idle; done returns the block to idle.
      if (start && !m_busy) begin
        m_busy = 1'b1; m_start = cyc; m_reads = 0; m_imd = 1'b0;
        m_sat_a = 1'b0; m_sat_b = 1'b0; m_done_due = -1;
        foreach (m_hist[i]) m_hist[i] = 0;
      end else if (cyc == m_done_due) begin
        m_busy = 1'b0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start(output int s);
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input bit toggle, output int dc);
    dc = -1;
    for (int i = 0; i < 1000; i++) begin
      if (a_done) begin
        dc = cyc;
        break;
      end
      if (toggle) en = ~en;
      tick();
    end
    if (dc < 0) begin
      checks++;
      failures++;
      $display("FAIL wait_done timeout at cycle %0d: got no done expected done", cyc);
    end
  endtask

  task automatic check_bins(input string tag, input int bin_x, input int cnt_x,
                            input int bin_y, input int cnt_y, input bit range16);
    int ea, eb;
    for (int b = 0; b < 256; b++) begin
      if (range16) ea = (b < 16) ? cnt_x : 0;
      else if (b == bin_x) ea = cnt_x;
      else if (b == bin_y) ea = cnt_y;
      else ea = 0;
      eb = min_int(ea, 15);
      chk($sformatf("%s_bin%0d_a", tag, b), a_mem[b], ea);
      chk($sformatf("%s_bin%0d_b", tag, b), b_mem[b], eb);
    end
  endtask

  initial begin
    int s, s2, dc;
    reset = 1'b1; start = 1'b0; en = 1'b0; fill = 1'b1;
    for (int i = 0; i < N; i++) pix_mem[i] = 8'd0;
    repeat (3) tick();
    fill = 1'b0;
    reset = 1'b0;
    tick();
    chk("reset_busy", a_busy | b_busy, 0);
    chk("reset_done", a_done | b_done, 0);
    chk("reset_imd", a_imd | b_imd, 0);
    chk("reset_sat", a_sat | b_sat, 0);
    chk("reset_iaddr", a_iaddr, 0);

    // Test 1: pixels 0..15, enable high.
    for (int i = 0; i < N; i++) pix_mem[i] = 8'(i);
    en = 1'b1;
    pulse_start(s);
    wait_done(1'b0, dc);
    chk("t1_done_latency", dc - s, 275);
    chk("t1_sat_a", a_sat, 0);
    chk("t1_imd", a_imd, 1);
    check_bins("t1", 0, 1, 0, 0, 1'b1);
    repeat (3) tick();
    chk("t1_idle_busy", a_busy, 0);

    // Test 2: all pixels 0xAA, forwarding every cycle; 4-bit counter saturates.
    for (int i = 0; i < N; i++) pix_mem[i] = 8'hAA;
    pulse_start(s);
    wait_done(1'b0, dc);
    chk("t2_done_latency", dc - s, 275);
    chk("t2_sat_a", a_sat, 0);
    chk("t2_sat_b", b_sat, 1);
    check_bins("t2", 170, 16, 0, 0, 1'b0);
    repeat (3) tick();

    // Test 3: alternating 0x3C/0xC3 with enable toggling every cycle.
    for (int i = 0; i < N; i++) pix_mem[i] = (i % 2 == 0) ? 8'h3C : 8'hC3;
    en = 1'b1;
    pulse_start(s);
    chk("t3_sat_cleared", b_sat, 0);
    wait_done(1'b1, dc);
    chk("t3_imd", a_imd, 1);
    check_bins("t3", 60, 8, 195, 8, 1'b0);
    repeat (3) tick();

    // Test 4: reset mid-accumulate, then a fresh run with a start while busy.
    for (int i = 0; i < N; i++) pix_mem[i] = (i < 10) ? 8'h55 : 8'hF0;
    en = 1'b1;
    pulse_start(s);
    while (cyc < s + 263) tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("t4_rst_busy", a_busy, 0);
    chk("t4_rst_imd", a_imd, 0);
    chk("t4_rst_iaddr", a_iaddr, 0);
    for (int i = 0; i < N; i++) pix_mem[i] = (i % 4 == 0) ? 8'h01 : 8'h80;
    pulse_start(s);
    repeat (20) tick();
    pulse_start(s2);
    wait_done(1'b0, dc);
    chk("t4_done_latency", dc - s, 275);
    check_bins("t4", 1, 4, 128, 12, 1'b0);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
